sparse_mult_by_e: RTL and testbench
===================================

Name: sparse_mult_by_e

Overview:
- Streaming sparse matrix–vector multiply by the constant 1×INPUT_LEN matrix E over GF(2).
- Consumes INPUT_LEN consecutive WIDTH-bit words per pass and emits one WIDTH-bit word per pass.
- The output is the XOR of the input words at the positions where E has a 1. The default E selects only the last word, index 10.
- Sits inline in a valid/ready streaming datapath; one pass out per INPUT_LEN words in, at full throughput.

Parameters:
- WIDTH, 96: data word width in bits.
- INPUT_LEN, 11: input words per pass.
- E_MASK, 11'b100_0000_0000: INPUT_LEN-bit row of E. Bit k=1 means input word k of the pass is XORed into the result.

Ports:
- i_clock  input  1  clock; all logic on the rising edge. One clock; reset is synchronous and active-high.
- i_reset  input  1  synchronous, active-high reset.
- i_input_data  input  WIDTH  upstream data word.
- i_input_valid  input  1  upstream word valid.
- o_input_ready  output  1  block can accept a word this cycle.
- o_output_data  output  WIDTH  result word, one per pass.
- o_output_valid  output  1  o_output_data is valid.
- i_output_ready  input  1  downstream accepts the result.

Behaviour:
- State:
  - word counter cnt, 0..INPUT_LEN-1;
  - accumulator acc, WIDTH bits;
  - output register plus valid flag.
  - No other FSM states: "accumulating" (cnt) and "output pending" (valid flag) are independent.
- Reset, synchronous and active-high:
  - cnt=0, acc=0, o_output_valid=0, o_output_data=0.
  - Reset mid-pass discards the partial pass and any pending output.
- o_input_ready = !i_reset && (!o_output_valid || i_output_ready). This is combinational, so there are no bubbles when downstream is ready.
- Input accept = i_input_valid && o_input_ready. The data word is masked = E_MASK[cnt] ? i_input_data : 0.
- Accept with cnt < INPUT_LEN-1:
  - acc <= acc ^ masked;
  - cnt <= cnt+1.
- Accept with cnt == INPUT_LEN-1, the last word of the pass:
  - o_output_data <= acc ^ masked;
  - o_output_valid <= 1;
  - acc <= 0;
  - cnt <= 0 (wrap).
- Latency: result valid 1 cycle after the last word of the pass is accepted.
- Output handshake:
  - Transfer when o_output_valid && i_output_ready. This clears valid unless a new pass completes in the same cycle.
  - Completion and transfer in the same cycle: valid stays 1 and the data is replaced with the new result.
- Backpressure:
  - While a result is pending and i_output_ready=0, o_input_ready=0.
  - Input valid words offered then are not consumed; cnt and acc hold.
  - The held o_output_data stays stable until transferred.
- With the default E_MASK the output equals input word 10 of each pass, and words 0..9 have no effect.
- Arithmetic is bitwise XOR over all WIDTH bits, with no carries.
- No output without a completed pass; idle inputs (valid=0) change nothing.

Test Plan:
- Idle: reset, then i_input_valid=0 and i_output_ready=1 for 100 cycles -> zero output transfers.
- Backpressure:
  - Stimulus: i_output_ready=0, data=0, i_input_valid=1 for 11–12 cycles; then valid=0 and ready=1.
  - Required response: exactly 1 output, value 0. o_input_ready drops after the 11th accepted word.
- Single pass:
  - Stimulus: i_output_ready=1; 11 words whose word 10 is {high=67108896, mid=65536, low=134217792} (32-bit fields, high..low); words 0..9 arbitrary.
  - Required response: exactly 1 output equal to that word, 1 cycle after the last input.
- Back-to-back passes:
  - Stimulus: one pass, idle, then 4 passes streamed continuously with ready=1. Last words are {96,65535,69696969}, {67108896,65534,250250}, {0,0,0} and {67108,65532,0}.
  - Required response: 5 outputs, in order, equal to each pass's last word. All 44 streamed words are accepted with no stall.
- Gaps: the same 5 passes with 20-cycle idle gaps between passes -> the same 5 outputs.
- Reset mid-pass: 5 words, reset, then a full 11-word pass -> exactly 1 output, equal to word 10 of the new pass.

Source files
------------

// File: rtl/sparse_mult_by_e.sv
// Streaming GF(2) product of a 1xINPUT_LEN constant row E with a word stream.
// One result word per INPUT_LEN accepted input words, valid/ready on both sides.
module sparse_mult_by_e #(
  parameter int unsigned WIDTH = 96,
  parameter int unsigned INPUT_LEN = 11,
  parameter logic [INPUT_LEN-1:0] E_MASK = 11'b100_0000_0000
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic [WIDTH-1:0] i_input_data,
  input  logic             i_input_valid,
  output logic             o_input_ready,
  output logic [WIDTH-1:0] o_output_data,
  output logic             o_output_valid,
  input  logic             i_output_ready
);

  localparam int unsigned CW =
    (INPUT_LEN > 1) ? $clog2(INPUT_LEN) : 1;
  localparam logic [CW-1:0] LAST = CW'(INPUT_LEN - 1);

  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             vld_q, vld_d;

  logic             accept;
  logic [WIDTH-1:0] masked;

  // Ready only falls when a result is stuck downstream.
  assign o_input_ready = !i_reset && (!vld_q || i_output_ready);
  assign accept = i_input_valid && o_input_ready;
  assign masked = E_MASK[cnt_q] ? i_input_data : '0;

  always_comb begin
    cnt_d  = cnt_q;
    acc_d  = acc_q;
    data_d = data_q;
    vld_d  = vld_q;
    if (vld_q && i_output_ready) begin
      vld_d = 1'b0;
    end
    if (accept) begin
      if (cnt_q == LAST) begin
        data_d = acc_q ^ masked;
        vld_d  = 1'b1;
        acc_d  = '0;
        cnt_d  = '0;
      end else begin
        acc_d = acc_q ^ masked;
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      cnt_q  <= '0;
      acc_q  <= '0;
      data_q <= '0;
      vld_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      acc_q  <= acc_d;
      data_q <= data_d;
      vld_q  <= vld_d;
    end
  end

  assign o_output_data  = data_q;
  assign o_output_valid = vld_q;

endmodule

// File: tb/tb_sparse_mult_by_e.sv
// Bench for sparse_mult_by_e: directed scenarios plus randomized traffic
// checked against a pass-level XOR model.
module tb_sparse_mult_by_e;

  localparam int W = 96;
  localparam int N = 11;
  localparam logic [N-1:0] EM = 11'b100_0000_0000;

  typedef logic [W-1:0] word_t;

  logic  clk = 1'b0;
  logic  rst = 1'b1;
  word_t din = '0;
  logic  vin = 1'b0;
  logic  rdy_in;
  word_t dout;
  logic  vout;
  logic  rdy_out = 1'b1;

  int nvec = 0;
  int nerr = 0;

  word_t acc_words[$];
  word_t obs[$];
  word_t exp_q[$];

  always #5 clk = ~clk;

  sparse_mult_by_e #(
    .WIDTH(W), .INPUT_LEN(N), .E_MASK(EM)
  ) dut (
    .i_clock(clk),
    .i_reset(rst),
    .i_input_data(din),
    .i_input_valid(vin),
    .o_input_ready(rdy_in),
    .o_output_data(dout),
    .o_output_valid(vout),
    .i_output_ready(rdy_out)
  );

  // Inputs change just after posedge, so negedge sees the values
  // the next edge will act on.
  always @(negedge clk) begin
    if (!rst) begin
      if (vin && rdy_in) acc_words.push_back(din);
      if (vout && rdy_out) obs.push_back(dout);
    end
  end

  function automatic void build_expected();
    exp_q.delete();
    for (int p = 0; p < acc_words.size() / N; p++) begin
      word_t r = '0;
      for (int k = 0; k < N; k++)
        if (EM[k]) r ^= acc_words[p*N+k];
      exp_q.push_back(r);
    end
  endfunction

  function automatic word_t rnd_word();
    return {$urandom(), $urandom(), $urandom()};
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle(input int n);
    vin = 1'b0;
    tick(n);
  endtask

  task automatic do_reset();
    vin = 1'b0;
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    acc_words.delete();
    obs.delete();
  endtask

  task automatic send_word(input word_t d, output bit stalled);
    vin = 1'b1;
    din = d;
    #1;
    stalled = !rdy_in;
    @(posedge clk);
    #1;
  endtask

  task automatic send_pass(input word_t last, output int stalls);
    bit s;
    stalls = 0;
    for (int k = 0; k < N; k++) begin
      send_word((k == N-1) ? last : rnd_word(), s);
      if (s) stalls++;
    end
  endtask

  task automatic test_reset();
    vin = 1'b1;
    din = rnd_word();
    rst = 1'b1;
    tick(2);
    nvec++;
    if (vout !== 1'b0) begin
      nerr++;
      $display("FAIL reset_valid got %b want 0", vout);
    end
    nvec++;
    if (dout !== '0) begin
      nerr++;
      $display("FAIL reset_data got %h want 0", dout);
    end
    nvec++;
    if (rdy_in !== 1'b0) begin
      nerr++;
      $display("FAIL reset_ready got %b want 0", rdy_in);
    end
    vin = 1'b0;
    rst = 1'b0;
    #1;
    nvec++;
    if (rdy_in !== 1'b1) begin
      nerr++;
      $display("FAIL post_reset_ready got %b want 1", rdy_in);
    end
    tick(1);
    acc_words.delete();
    obs.delete();
  endtask

  task automatic test_idle();
    do_reset();
    rdy_out = 1'b1;
    din = rnd_word();
    idle(100);
    nvec++;
    if (obs.size() != 0) begin
      nerr++;
      $display("FAIL idle_outputs got %0d want 0", obs.size());
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    rdy_out = 1'b0;
    vin = 1'b1;
    din = '0;
    tick(12);
    #1;
    nvec++;
    if (acc_words.size() != N) begin
      nerr++;
      $display("FAIL bp_accepted got %0d want %0d",
               acc_words.size(), N);
    end
    nvec++;
    if (rdy_in !== 1'b0) begin
      nerr++;
      $display("FAIL bp_ready got %b want 0", rdy_in);
    end
    nvec++;
    if (vout !== 1'b1) begin
      nerr++;
      $display("FAIL bp_pending got %b want 1", vout);
    end
    vin = 1'b0;
    rdy_out = 1'b1;
    tick(4);
    nvec++;
    if (obs.size() != 1) begin
      nerr++;
      $display("FAIL bp_outputs got %0d want 1", obs.size());
    end else begin
      nvec++;
      if (obs[0] !== '0) begin
        nerr++;
        $display("FAIL bp_value got %h want 0", obs[0]);
      end
    end
  endtask

  task automatic test_single_pass();
    word_t last;
    bit s;
    last = {32'd67108896, 32'd65536, 32'd134217792};
    do_reset();
    rdy_out = 1'b1;
    for (int k = 0; k < N-1; k++) send_word(rnd_word(), s);
    nvec++;
    if (vout !== 1'b0) begin
      nerr++;
      $display("FAIL single_early got %b want 0", vout);
    end
    send_word(last, s);
    nvec++;
    if (vout !== 1'b1 || dout !== last) begin
      nerr++;
      $display("FAIL single_latency got v=%b %h want v=1 %h",
               vout, dout, last);
    end
    idle(4);
    nvec++;
    if (obs.size() != 1) begin
      nerr++;
      $display("FAIL single_count got %0d want 1", obs.size());
    end else begin
      nvec++;
      if (obs[0] !== last) begin
        nerr++;
        $display("FAIL single_value got %h want %h", obs[0], last);
      end
    end
  endtask

  task automatic run_five(input int gap, input string tag);
    word_t lasts[5];
    int st;
    int total;
    lasts[0] = rnd_word();
    lasts[1] = {32'd96, 32'd65535, 32'd69696969};
    lasts[2] = {32'd67108896, 32'd65534, 32'd250250};
    lasts[3] = '0;
    lasts[4] = {32'd67108, 32'd65532, 32'd0};
    do_reset();
    rdy_out = 1'b1;
    send_pass(lasts[0], st);
    idle(3);
    total = 0;
    for (int p = 1; p < 5; p++) begin
      send_pass(lasts[p], st);
      total += st;
      if (gap > 0) idle(gap);
    end
    idle(4);
    nvec++;
    if (total != 0) begin
      nerr++;
      $display("FAIL %s_stalls got %0d want 0", tag, total);
    end
    nvec++;
    if (obs.size() != 5) begin
      nerr++;
      $display("FAIL %s_count got %0d want 5", tag, obs.size());
    end else begin
      for (int p = 0; p < 5; p++) begin
        nvec++;
        if (obs[p] !== lasts[p]) begin
          nerr++;
          $display("FAIL %s_out%0d got %h want %h",
                   tag, p, obs[p], lasts[p]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    run_five(0, "b2b");
  endtask

  task automatic test_gaps();
    run_five(20, "gaps");
  endtask

  task automatic test_reset_mid_pass();
    word_t last;
    bit s;
    int st;
    do_reset();
    rdy_out = 1'b1;
    for (int k = 0; k < 5; k++) send_word(rnd_word(), s);
    do_reset();
    last = rnd_word();
    send_pass(last, st);
    idle(4);
    nvec++;
    if (obs.size() != 1) begin
      nerr++;
      $display("FAIL midrst_count got %0d want 1", obs.size());
    end else begin
      nvec++;
      if (obs[0] !== last) begin
        nerr++;
        $display("FAIL midrst_value got %h want %h", obs[0], last);
      end
    end
  endtask

  task automatic test_random();
    bit    hold;
    word_t held;
    int    bad;
    do_reset();
    hold = 1'b0;
    held = '0;
    bad = 0;
    for (int c = 0; c < 600; c++) begin
      if (hold && (vout !== 1'b1 || dout !== held)) bad++;
      vin = ($urandom_range(0, 9) < 7);
      rdy_out = ($urandom_range(0, 9) < 5);
      din = rnd_word();
      #1;
      hold = vout && !rdy_out;
      held = dout;
      @(posedge clk);
      #1;
    end
    vin = 1'b0;
    rdy_out = 1'b1;
    tick(4);
    nvec++;
    if (bad != 0) begin
      nerr++;
      $display("FAIL rand_hold got %0d unstable want 0", bad);
    end
    build_expected();
    nvec++;
    if (obs.size() != exp_q.size()) begin
      nerr++;
      $display("FAIL rand_count got %0d want %0d",
               obs.size(), exp_q.size());
    end else begin
      for (int p = 0; p < exp_q.size(); p++) begin
        nvec++;
        if (obs[p] !== exp_q[p]) begin
          nerr++;
          $display("FAIL rand_out%0d got %h want %h",
                   p, obs[p], exp_q[p]);
        end
      end
    end
  endtask

  initial begin
    tick(1);
    test_reset();
    test_idle();
    test_backpressure();
    test_single_pass();
    test_back_to_back();
    test_gaps();
    test_reset_mid_pass();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
